fpga_reset_sequencer: RTL



---
 rtl/fpga_reset_seq_pkg.sv | 25 ++
 rtl/fpga_reset_debounce.sv | 47 ++++
 rtl/fpga_reset_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fpga_reset_seq_pkg.sv
// rtl/fpga_reset_seq_pkg.sv - state encodings and counter sizing for fpga_reset_sequencer
package fpga_reset_seq_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_MMCM_RST   = 3'd0;
    localparam state_t ST_WAIT_LOCK  = 3'd1;
    localparam state_t ST_STABLE     = 3'd2;
    localparam state_t ST_PERIPH_REL = 3'd3;
    localparam state_t ST_RUN        = 3'd4;
    localparam state_t ST_BTN_HOLD   = 3'd5;

    // One shared counter serves every timed state, so it is sized for the longest wait.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/fpga_reset_debounce.sv
// rtl/fpga_reset_debounce.sv - 2-flop synchronizer and debouncer for the board reset button
module fpga_reset_debounce
    import fpga_reset_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pad_i,
    output logic btn_db_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]      sync_q, sync_d;
    logic            btn_q, btn_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing cycles; any agreeing cycle restarts the count.
    always_comb begin
        sync_d = {sync_q[0], pad_i};
        btn_d  = btn_q;
        cnt_d  = '0;
        if (sync_q[1] != btn_q) begin
            if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_d = ~btn_q;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            btn_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            btn_q  <= btn_d;
            cnt_q  <= cnt_d;
        end
    end

    assign btn_db_o = btn_q;

endmodule

// File: rtl/fpga_reset_sequencer.sv
// rtl/fpga_reset_sequencer.sv - MMCM lock / peripheral / SoC reset sequencer
// Optional lock-loss counter output enabled by FPGA_RESET_SEQ_LOCK_LOSS_CNT_EN.
module fpga_reset_sequencer
    import fpga_reset_seq_pkg::*;
#(
    parameter int MMCM_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES  = 65536,
    parameter int LOCK_STABLE_CYCLES   = 1024,
    parameter int DEBOUNCE_CYCLES      = 3000000,
    parameter int PERIPH_TO_SOC_CYCLES = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               mmcm_locked_i,
    input  logic               pad_reset_i,
    output logic               mmcm_rst_o,
    output logic               periph_rst_no,
    output logic               soc_rst_no,
    output logic               ready_o,
    output logic [STATE_W-1:0] state_o
`ifdef FPGA_RESET_SEQ_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0]         lock_loss_cnt_o
`endif
);

    localparam int CNT_W = cnt_width(MMCM_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                     LOCK_STABLE_CYCLES, PERIPH_TO_SOC_CYCLES);

    logic [1:0]       lock_sync_q, lock_sync_d;
    logic             lock_s;
    logic             btn_db;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mmcm_rst_q, mmcm_rst_d;
    logic             periph_rst_n_q, periph_rst_n_d;
    logic             soc_rst_n_q, soc_rst_n_d;
    logic             ready_q, ready_d;

    fpga_reset_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .pad_i    (pad_reset_i),
        .btn_db_o (btn_db)
    );

    assign lock_sync_d = {lock_sync_q[0], mmcm_locked_i};
    assign lock_s      = lock_sync_q[1];

    // Lock loss is tested before the button everywhere so it always wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_MMCM_RST: begin
                if (cnt_q == CNT_W'(MMCM_RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s)                                        state_d = ST_STABLE;
                else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) state_d = ST_MMCM_RST;
            end
            ST_STABLE: begin
                if (!lock_s)                                      state_d = ST_MMCM_RST;
                else if (btn_db)                                  state_d = ST_BTN_HOLD;
                else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) state_d = ST_PERIPH_REL;
            end
            ST_PERIPH_REL: begin
                if (!lock_s)                                        state_d = ST_MMCM_RST;
                else if (btn_db)                                    state_d = ST_BTN_HOLD;
                else if (cnt_q == CNT_W'(PERIPH_TO_SOC_CYCLES - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s)     state_d = ST_MMCM_RST;
                else if (btn_db) state_d = ST_BTN_HOLD;
            end
            ST_BTN_HOLD: begin
                if (!lock_s)      state_d = ST_MMCM_RST;
                else if (!btn_db) state_d = ST_STABLE;
            end
            default: state_d = ST_MMCM_RST;
        endcase

        if (state_d != state_q) cnt_d = '0;
        else if (&cnt_q)        cnt_d = cnt_q;
        else                    cnt_d = cnt_q + CNT_W'(1);

        // Outputs are decoded from the next state so they change on the same edge as state_q.
        mmcm_rst_d     = (state_d == ST_MMCM_RST);
        periph_rst_n_d = (state_d == ST_PERIPH_REL) || (state_d == ST_RUN);
        soc_rst_n_d    = (state_d == ST_RUN);
        ready_d        = (state_d == ST_RUN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_sync_q    <= '0;
            state_q        <= ST_MMCM_RST;
            cnt_q          <= '0;
            mmcm_rst_q     <= 1'b1;
            periph_rst_n_q <= 1'b0;
            soc_rst_n_q    <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            lock_sync_q    <= lock_sync_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mmcm_rst_q     <= mmcm_rst_d;
            periph_rst_n_q <= periph_rst_n_d;
            soc_rst_n_q    <= soc_rst_n_d;
            ready_q        <= ready_d;
        end
    end

    assign mmcm_rst_o    = mmcm_rst_q;
    assign periph_rst_no = periph_rst_n_q;
    assign soc_rst_no    = soc_rst_n_q;
    assign ready_o       = ready_q;
    assign state_o       = state_q;

`ifdef FPGA_RESET_SEQ_LOCK_LOSS_CNT_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if ((state_d == ST_MMCM_RST) && (state_q != ST_MMCM_RST) && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) loss_cnt_q <= 8'd0;
        else         loss_cnt_q <= loss_cnt_d;
    end

    assign lock_loss_cnt_o = loss_cnt_q;
`endif

endmodule
